// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline stages/cache handshake and hazard_unit.
// CNT_W sets the width of the performance-counter outputs and must match the unit's CNT_W.
interface hazard_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_wsel;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             dhit;
  logic             ihit;
  logic             mem_branch_taken;
  logic             wb_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halted;
  logic             timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_wsel,
           mem_dREN, mem_dWEN, dhit, ihit, mem_branch_taken, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, timeout,
           stall_cnt, flush_cnt
  );

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_wsel,
           mem_dREN, mem_dWEN, dhit, ihit, mem_branch_taken, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, timeout,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard detection: stalls, bubbles and flushes for the 5-stage core.
// Optional macro HAZARD_PERF_EN builds the stall/flush performance counters.
module hazard_unit #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 32
) (
  input logic        CLK,
  input logic        RST,
  hazard_unit_if.slave hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WMAX    = WAIT_MAX[WCNT_W-1:0];
  localparam logic [WCNT_W-1:0] WMAX_M1 = WMAX - 1'b1;

  state_t            r_state;
  state_t            w_state_next;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_timeout;

  logic       w_wait;
  logic       w_load_use;
  logic       w_halt_pri;
  logic [4:0] w_en;     // {pc, ifid, idex, exmem, memwb}
  logic [2:0] w_flush;  // {ifid, idex, exmem}
  logic       w_halted;

  assign w_wait     = (hz.mem_dREN | hz.mem_dWEN) & ~hz.dhit;
  assign w_halt_pri = (r_state == HALT) | hz.wb_halt;
  assign w_load_use = hz.ex_memread & (hz.ex_wsel != 5'd0) &
                      ((hz.id_uses_rs & (hz.id_rs == hz.ex_wsel)) |
                       (hz.id_uses_rt & (hz.id_rt == hz.ex_wsel)));

  always_ff @(posedge CLK) begin
    if (RST) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (hz.wb_halt) begin
      w_state_next = HALT;
    end else begin
      case (r_state)
        RUN:      if (w_wait) w_state_next = MEM_WAIT;
        MEM_WAIT: if (hz.dhit) w_state_next = RUN;
        default:  w_state_next = HALT;
      endcase
    end
  end

  // First matching condition wins; lower-priority hazards stay frozen in their latches.
  always_comb begin
    w_en     = 5'b11111;
    w_flush  = 3'b000;
    w_halted = 1'b0;
    if (RST) begin
      w_en    = 5'b00000;
      w_flush = 3'b111;
    end else if (w_halt_pri) begin
      w_en     = 5'b00000;
      w_halted = 1'b1;
    end else if (w_wait) begin
      w_en = 5'b00000;
    end else if (hz.mem_branch_taken) begin
      w_flush = 3'b111;
    end else if (w_load_use) begin
      w_en    = 5'b00111;
      w_flush = 3'b010;
    end else if (!hz.ihit) begin
      w_en    = 5'b01111;
      w_flush = 3'b100;
    end
  end

  assign hz.pc_en       = w_en[4];
  assign hz.ifid_en     = w_en[3];
  assign hz.idex_en     = w_en[2];
  assign hz.exmem_en    = w_en[1];
  assign hz.memwb_en    = w_en[0];
  assign hz.ifid_flush  = w_flush[2];
  assign hz.idex_flush  = w_flush[1];
  assign hz.exmem_flush = w_flush[0];
  assign hz.halted      = w_halted;
  assign hz.timeout     = r_timeout;

  // Counter value after this cycle reaches WMAX when it is at WMAX-1 or already saturated.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (r_state == RUN && w_state_next == MEM_WAIT) begin
      r_wait_cnt <= '0;
    end else if (r_state == MEM_WAIT && !hz.wb_halt) begin
      if (r_wait_cnt != WMAX) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_wait && r_wait_cnt >= WMAX_M1) r_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic             w_stall_cycle;
  logic             w_flush_cycle;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_stall_cycle = ~RST & ~w_halt_pri & ~w_en[4];
  assign w_flush_cycle = ~RST & ~w_halt_pri & ~w_wait & hz.mem_branch_taken;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_cycle) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_cycle) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random stimulus
// against a priority-table reference model.
module tb_hazard_unit;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 32;

  logic CLK;
  logic RST;

  hazard_unit_if #(.CNT_W(CNT_W)) hz ();

  hazard_unit #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hz)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // {pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f, halted}
  logic [8:0] dut_vec;
  assign dut_vec = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                    hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.halted};

  // Reference model state
  bit          m_halted;
  bit          m_waiting;
  int          m_wait_cnt;
  bit          m_timeout;
  logic [31:0] m_stall;
  logic [31:0] m_flush;
  int          e_level;
  bit          e_wait;
  logic [8:0]  e_vec;

  task automatic model_comb();
    bit lu;
    e_wait = (hz.mem_dREN || hz.mem_dWEN) && !hz.dhit;
    lu = hz.ex_memread && (hz.ex_wsel != 0) &&
         ((hz.id_uses_rs && hz.id_rs == hz.ex_wsel) ||
          (hz.id_uses_rt && hz.id_rt == hz.ex_wsel));
    if (RST)                          e_level = 1;
    else if (m_halted || hz.wb_halt)  e_level = 2;
    else if (e_wait)                  e_level = 3;
    else if (hz.mem_branch_taken)     e_level = 4;
    else if (lu)                      e_level = 5;
    else if (!hz.ihit)                e_level = 6;
    else                              e_level = 7;
    case (e_level)
      1:       e_vec = 9'b00000_111_0;
      2:       e_vec = 9'b00000_000_1;
      3:       e_vec = 9'b00000_000_0;
      4:       e_vec = 9'b11111_111_0;
      5:       e_vec = 9'b00111_010_0;
      6:       e_vec = 9'b01111_100_0;
      default: e_vec = 9'b11111_000_0;
    endcase
  endtask

  task automatic model_seq();
    model_comb();
    if (RST) begin
      m_halted = 0; m_waiting = 0; m_wait_cnt = 0; m_timeout = 0;
      m_stall = 0;  m_flush = 0;
    end else begin
`ifdef HAZARD_PERF_EN
      if (e_level >= 3 && e_vec[8] == 1'b0) m_stall = m_stall + 1;
      if (e_level == 4) m_flush = m_flush + 1;
`endif
      if (m_halted || hz.wb_halt) begin
        m_halted = 1;
      end else if (m_waiting) begin
        if (m_wait_cnt < WAIT_MAX) m_wait_cnt++;
        if (e_wait && m_wait_cnt == WAIT_MAX) m_timeout = 1;
        if (hz.dhit) m_waiting = 0;
      end else if (e_wait) begin
        m_waiting  = 1;
        m_wait_cnt = 0;
      end
    end
  endtask

  // Advance one clock: model follows the edge, return at the negedge to drive/sample.
  task automatic tick();
    @(posedge CLK);
    model_seq();
    @(negedge CLK);
  endtask

  task automatic set_idle();
    hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
    hz.ex_memread = 0; hz.ex_wsel = 0; hz.mem_dREN = 0; hz.mem_dWEN = 0;
    hz.dhit = 0; hz.ihit = 1; hz.mem_branch_taken = 0; hz.wb_halt = 0;
  endtask

  task automatic do_reset();
    set_idle();
    RST = 1;
    tick();
    RST = 0;
  endtask

  task automatic test_reset();
    set_idle();
    RST = 1;
    #1; model_comb();
    n_tests++;
    if (dut_vec !== 9'b00000_111_0) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=%b", dut_vec, 9'b00000_111_0);
    end
    tick();
    RST = 0;
    #1; model_comb();
    n_tests++;
    if (dut_vec !== e_vec || dut_vec !== 9'b11111_000_0) begin
      n_fail++; $display("FAIL reset_release got=%b want=%b", dut_vec, e_vec);
    end
    n_tests++;
    if (hz.timeout !== 1'b0 || hz.stall_cnt !== 32'd0 || hz.flush_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_regs got timeout=%b stall=%0d flush=%0d want 0/0/0",
                         hz.timeout, hz.stall_cnt, hz.flush_cnt);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    hz.ex_memread = 1; hz.ex_wsel = 5; hz.id_rs = 5; hz.id_uses_rs = 1;
    #1; model_comb();
    n_tests++;
    if (dut_vec !== e_vec || dut_vec !== 9'b00111_010_0) begin
      n_fail++; $display("FAIL load_use_rs got=%b want=%b", dut_vec, e_vec);
    end
    tick();
    hz.ex_memread = 0;
    #1; model_comb();
    n_tests++;
    if (dut_vec !== 9'b11111_000_0) begin
      n_fail++; $display("FAIL load_use_after got=%b want=%b", dut_vec, 9'b11111_000_0);
    end
    tick();
    hz.ex_memread = 1; hz.ex_wsel = 0; hz.id_rs = 0;
    #1; model_comb();
    n_tests++;
    if (dut_vec !== 9'b11111_000_0) begin
      n_fail++; $display("FAIL load_use_r0 got=%b want=%b", dut_vec, 9'b11111_000_0);
    end
    hz.ex_wsel = 9; hz.id_rs = 9; hz.id_uses_rs = 0; hz.id_rt = 9; hz.id_uses_rt = 1;
    #1; model_comb();
    n_tests++;
    if (dut_vec !== 9'b00111_010_0) begin
      n_fail++; $display("FAIL load_use_rt got=%b want=%b", dut_vec, 9'b00111_010_0);
    end
    hz.id_uses_rt = 0;
    #1;
    n_tests++;
    if (dut_vec !== 9'b11111_000_0) begin
      n_fail++; $display("FAIL load_use_unused got=%b want=%b", dut_vec, 9'b11111_000_0);
    end
    tick();
    set_idle();
    $display("[TB] test_load_use done");
  endtask

  task automatic test_data_wait();
    do_reset();
    hz.mem_dREN = 1; hz.dhit = 0;
    for (int c = 0; c < 3; c++) begin
      #1; model_comb();
      n_tests++;
      if (dut_vec !== 9'b00000_000_0) begin
        n_fail++; $display("FAIL data_wait_c%0d got=%b want=%b", c, dut_vec, 9'b00000_000_0);
      end
      tick();
    end
    hz.dhit = 1;
    #1; model_comb();
    n_tests++;
    if (dut_vec !== 9'b11111_000_0) begin
      n_fail++; $display("FAIL data_wait_hit got=%b want=%b", dut_vec, 9'b11111_000_0);
    end
    tick();
    hz.mem_dREN = 0; hz.ihit = 0;
    #1; model_comb();
    n_tests++;
    if (dut_vec !== 9'b01111_100_0) begin
      n_fail++; $display("FAIL data_wait_resume got=%b want=%b", dut_vec, 9'b01111_100_0);
    end
    tick();
    set_idle();
    $display("[TB] test_data_wait done");
  endtask

  task automatic test_timeout();
    do_reset();
    hz.mem_dREN = 1; hz.dhit = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_tests++;
      if (hz.timeout !== m_timeout || hz.timeout !== (k >= 5)) begin
        n_fail++; $display("FAIL timeout_k%0d got=%b want=%b", k, hz.timeout, (k >= 5));
      end
    end
    hz.dhit = 1;
    tick();
    hz.mem_dREN = 0;
    n_tests++;
    if (hz.timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky got=%b want=1", hz.timeout);
    end
    RST = 1;
    tick();
    RST = 0;
    n_tests++;
    if (hz.timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear got=%b want=0", hz.timeout);
    end
    set_idle();
    $display("[TB] test_timeout done");
  endtask

  task automatic test_branch_during_wait();
    do_reset();
    hz.mem_branch_taken = 1; hz.mem_dWEN = 1; hz.dhit = 0;
    for (int c = 0; c < 2; c++) begin
      #1; model_comb();
      n_tests++;
      if (dut_vec !== 9'b00000_000_0) begin
        n_fail++; $display("FAIL branch_wait_c%0d got=%b want=%b", c, dut_vec, 9'b00000_000_0);
      end
      tick();
    end
    hz.dhit = 1;
    #1; model_comb();
    n_tests++;
    if (dut_vec !== 9'b11111_111_0) begin
      n_fail++; $display("FAIL branch_wait_hit got=%b want=%b", dut_vec, 9'b11111_111_0);
    end
    tick();
    set_idle();
    $display("[TB] test_branch_during_wait done");
  endtask

  task automatic test_halt();
    do_reset();
    hz.wb_halt = 1;
    #1; model_comb();
    n_tests++;
    if (dut_vec !== 9'b00000_000_1) begin
      n_fail++; $display("FAIL halt_now got=%b want=%b", dut_vec, 9'b00000_000_1);
    end
    tick();
    hz.wb_halt = 0;
    for (int c = 0; c < 4; c++) begin
      hz.ihit = 1'($urandom_range(0, 1));
      hz.dhit = 1'($urandom_range(0, 1));
      hz.mem_dREN = 1'($urandom_range(0, 1));
      hz.mem_branch_taken = 1'($urandom_range(0, 1));
      #1; model_comb();
      n_tests++;
      if (dut_vec !== 9'b00000_000_1) begin
        n_fail++; $display("FAIL halt_hold_c%0d got=%b want=%b", c, dut_vec, 9'b00000_000_1);
      end
      tick();
    end
    RST = 1;
    tick();
    RST = 0;
    set_idle();
    #1; model_comb();
    n_tests++;
    if (dut_vec !== 9'b11111_000_0) begin
      n_fail++; $display("FAIL halt_reset got=%b want=%b", dut_vec, 9'b11111_000_0);
    end
    $display("[TB] test_halt done");
  endtask

  task automatic test_perf();
    logic [31:0] want_stall;
    logic [31:0] want_flush;
`ifdef HAZARD_PERF_EN
    want_stall = 5; want_flush = 1;
`else
    want_stall = 0; want_flush = 0;
`endif
    do_reset();
    hz.ex_memread = 1; hz.ex_wsel = 3; hz.id_rt = 3; hz.id_uses_rt = 1;
    tick(); tick();
    set_idle();
    hz.ihit = 0;
    tick(); tick(); tick();
    hz.ihit = 1; hz.mem_branch_taken = 1;
    tick();
    set_idle();
    tick();
    n_tests++;
    if (hz.stall_cnt !== want_stall || hz.stall_cnt !== m_stall) begin
      n_fail++; $display("FAIL perf_stall got=%0d want=%0d", hz.stall_cnt, want_stall);
    end
    n_tests++;
    if (hz.flush_cnt !== want_flush || hz.flush_cnt !== m_flush) begin
      n_fail++; $display("FAIL perf_flush got=%0d want=%0d", hz.flush_cnt, want_flush);
    end
    $display("[TB] test_perf stall=%0d flush=%0d", hz.stall_cnt, hz.flush_cnt);
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      RST = ($urandom_range(0, 59) == 0);
      hz.wb_halt = ($urandom_range(0, 199) == 0);
      hz.id_rs = 5'($urandom_range(0, 3));
      hz.id_rt = 5'($urandom_range(0, 3));
      hz.id_uses_rs = 1'($urandom_range(0, 1));
      hz.id_uses_rt = 1'($urandom_range(0, 1));
      hz.ex_memread = 1'($urandom_range(0, 1));
      hz.ex_wsel = 5'($urandom_range(0, 3));
      hz.mem_dREN = ($urandom_range(0, 3) == 0);
      hz.mem_dWEN = ($urandom_range(0, 5) == 0);
      hz.dhit = ($urandom_range(0, 2) == 0);
      hz.ihit = ($urandom_range(0, 3) != 0);
      hz.mem_branch_taken = ($urandom_range(0, 7) == 0);
      #1; model_comb();
      n_tests++;
      if (dut_vec !== e_vec) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_comb_c%0d got=%b want=%b", c, dut_vec, e_vec);
      end
      tick();
      n_tests++;
      if (hz.timeout !== m_timeout || hz.stall_cnt !== m_stall || hz.flush_cnt !== m_flush) begin
        n_fail++; errs++;
        if (errs < 10)
          $display("FAIL rand_regs_c%0d got to=%b st=%0d fl=%0d want to=%b st=%0d fl=%0d", c,
                   hz.timeout, hz.stall_cnt, hz.flush_cnt, m_timeout, m_stall, m_flush);
      end
    end
    RST = 0;
    set_idle();
    $display("[TB] test_random done, %0d errors", errs);
  endtask

  initial begin
    RST = 1;
    set_idle();
    m_halted = 0; m_waiting = 0; m_wait_cnt = 0; m_timeout = 0;
    m_stall = 0; m_flush = 0;
    @(negedge CLK);
    test_reset();
    test_load_use();
    test_data_wait();
    test_timeout();
    test_branch_during_wait();
    test_halt();
    test_perf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
